// File: rtl/lab1_imul_mul_sched_pkg.sv
// rtl/lab1_imul_mul_sched_pkg.sv - shared widths and helpers for the multiplier scheduler
package lab1_imul_sched_pkg;

  localparam int MSG_IN_NBITS  = 64;
  localparam int MSG_OUT_NBITS = 32;

  function automatic int tag_nbits(input int nreqs);
    return (nreqs <= 2) ? 1 : $clog2(nreqs);
  endfunction

endpackage

// File: rtl/lab1_imul_mul_sched_if.sv
// rtl/lab1_imul_mul_sched_if.sv - requester, response and multiplier-side bundle of the scheduler
interface lab1_imul_mul_sched_if
  import lab1_imul_sched_pkg::*;
#(
  parameter int p_nreqs = 4
);

  logic [p_nreqs-1:0]              req_val;
  logic [p_nreqs-1:0]              req_rdy;
  logic [MSG_IN_NBITS*p_nreqs-1:0] req_msg;
  logic [p_nreqs-1:0]              resp_val;
  logic [p_nreqs-1:0]              resp_rdy;
  logic [MSG_OUT_NBITS-1:0]        resp_msg;
  logic                            mul_istream_val;
  logic                            mul_istream_rdy;
  logic [MSG_IN_NBITS-1:0]         mul_istream_msg;
  logic                            mul_ostream_val;
  logic                            mul_ostream_rdy;
  logic [MSG_OUT_NBITS-1:0]        mul_ostream_msg;
  logic                            busy;

  modport slave (
    input  req_val, req_msg, resp_rdy, mul_istream_rdy, mul_ostream_val, mul_ostream_msg,
    output req_rdy, resp_val, resp_msg, mul_istream_val, mul_istream_msg, mul_ostream_rdy, busy
  );

  modport master (
    output req_val, req_msg, resp_rdy, mul_istream_rdy, mul_ostream_val, mul_ostream_msg,
    input  req_rdy, resp_val, resp_msg, mul_istream_val, mul_istream_msg, mul_ostream_rdy, busy
  );

endinterface

// File: rtl/lab1_imul_mul_sched_tag_fifo.sv
// rtl/lab1_imul_mul_sched_tag_fifo.sv - synchronous FIFO holding the requester id of each in-flight op
module lab1_imul_tag_fifo #(
  parameter int p_width = 2,
  parameter int p_depth = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_i,
  input  logic [p_width-1:0] push_data_i,
  input  logic               pop_i,
  output logic [p_width-1:0] head_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int CW = $clog2(p_depth + 1);

  logic [p_width-1:0] mem_q [p_depth];
  logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(p_depth - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(p_depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = ptr_inc(wr_q);
    if (do_pop)  rd_d = ptr_inc(rd_q);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload needs no reset: empty_o masks stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/lab1_imul_mul_sched.sv
// rtl/lab1_imul_mul_sched.sv - round-robin sharing of one multiplier among p_nreqs requesters
module lab1_imul_mul_sched
  import lab1_imul_sched_pkg::*;
#(
  parameter int p_nreqs    = 4,
  parameter int p_max_infl = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  lab1_imul_mul_sched_if.slave  bus
);

  localparam int TW = tag_nbits(p_nreqs);
  typedef logic [TW-1:0] tag_t;

  tag_t rr_ptr_q, rr_ptr_d;
  tag_t lock_tag_q, lock_tag_d;
  logic lock_q, lock_d;
  tag_t grant, head;
  logic any_val, full, empty, issue_fire, ret_fire;

  // A stalled grant is pinned so a newly valid higher-priority port cannot steal it.
  always_comb begin
    logic found;
    int   idx;
    found = 1'b0;
    idx   = 0;
    grant = rr_ptr_q;
    if (lock_q && bus.req_val[lock_tag_q]) begin
      grant = lock_tag_q;
    end else begin
      for (int k = 0; k < p_nreqs; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= p_nreqs) idx = idx - p_nreqs;
        if (!found && bus.req_val[tag_t'(idx)]) begin
          found = 1'b1;
          grant = tag_t'(idx);
        end
      end
    end
  end

  assign any_val             = |bus.req_val;
  assign bus.mul_istream_val = ~reset & any_val & ~full;
  assign issue_fire          = bus.mul_istream_val & bus.mul_istream_rdy;
  assign bus.mul_ostream_rdy = ~reset & ~empty & bus.resp_rdy[head];
  assign ret_fire            = bus.mul_ostream_val & bus.mul_ostream_rdy;
  assign bus.resp_msg        = bus.mul_ostream_msg;
  assign bus.busy            = ~reset & ~empty;

  always_comb begin
    bus.mul_istream_msg = '0;
    for (int i = 0; i < p_nreqs; i++) begin
      bus.req_rdy[i]  = ~reset & bus.mul_istream_rdy & ~full & (grant == tag_t'(i));
      bus.resp_val[i] = ~reset & bus.mul_ostream_val & ~empty & (head == tag_t'(i));
      if (grant == tag_t'(i)) bus.mul_istream_msg = bus.req_msg[MSG_IN_NBITS*i +: MSG_IN_NBITS];
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = bus.mul_istream_val & ~bus.mul_istream_rdy;
    lock_tag_d = grant;
    if (issue_fire) rr_ptr_d = (grant == tag_t'(p_nreqs - 1)) ? '0 : grant + tag_t'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_tag_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_tag_q <= lock_tag_d;
    end
  end

  lab1_imul_tag_fifo #(
    .p_width (TW),
    .p_depth (p_max_infl)
  ) u_tag_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (issue_fire),
    .push_data_i (grant),
    .pop_i       (ret_fire),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty)
  );

endmodule
